// File: rtl/cv32e40x_rf_wport_arbiter.sv
// Register-file write-port arbiter: the WB-stage result and queued XIF coprocessor results
// share one RF write port. XIF results wait in a small circular FIFO and drain in idle
// slots. A starvation counter forces a drain slot by stalling WB.
// Optional: define CV32E40X_RF_ARB_BYPASS_EN to write an accepted XIF result in the same
// cycle when the FIFO is empty and WB is idle.
module cv32e40x_rf_wport_arbiter #(
  parameter int unsigned XIF_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter int unsigned X_ID_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_we_i,
  input  logic [4:0]            pipe_waddr_i,
  input  logic [31:0]           pipe_wdata_i,
  output logic                  pipe_ready_o,
  input  logic                  xif_valid_i,
  output logic                  xif_ready_o,
  input  logic                  xif_we_i,
  input  logic [4:0]            xif_rd_i,
  input  logic [31:0]           xif_data_i,
  input  logic [X_ID_WIDTH-1:0] xif_id_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  output logic                  rf_xif_o,
  output logic [X_ID_WIDTH-1:0] rf_id_o,
  output logic                  fifo_empty_o
);

  localparam int unsigned PTR_W = $clog2(XIF_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            q_rd   [XIF_FIFO_DEPTH];
  logic [31:0]           q_data [XIF_FIFO_DEPTH];
  logic [X_ID_WIDTH-1:0] q_id   [XIF_FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr, slot_off;
  logic [CNT_W-1:0] count;
  logic [ST_W-1:0]  starve_cnt;

  logic empty, full, accept, bypass, push, pop, force_drain, wb_win, rd_hazard;

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(XIF_FIFO_DEPTH));
  assign xif_ready_o  = !full;
  assign fifo_empty_o = empty;
  assign accept       = xif_valid_i && xif_ready_o && xif_we_i;
  assign force_drain  = (starve_cnt == ST_W'(STARVE_LIMIT)) && !empty;

`ifdef CV32E40X_RF_ARB_BYPASS_EN
  assign bypass = accept && empty && !pipe_we_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result is written directly, so it never enters the queue
  assign push = accept && !bypass;

  // Write-port grant: forced drain, then WB, then queued XIF, then bypass
  always_comb begin
    pop          = 1'b0;
    wb_win       = 1'b0;
    pipe_ready_o = 1'b1;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    rf_xif_o     = 1'b0;
    rf_id_o      = '0;
    if (force_drain || (!pipe_we_i && !empty)) begin
      pop          = 1'b1;
      pipe_ready_o = !force_drain;
      rf_we_o      = (q_rd[rd_ptr] != 5'd0);
      rf_waddr_o   = q_rd[rd_ptr];
      rf_wdata_o   = q_data[rd_ptr];
      rf_xif_o     = 1'b1;
      rf_id_o      = q_id[rd_ptr];
    end else if (pipe_we_i) begin
      wb_win     = 1'b1;
      rf_we_o    = 1'b1;
      rf_waddr_o = pipe_waddr_i;
      rf_wdata_o = pipe_wdata_i;
    end else if (bypass) begin
      rf_we_o    = (xif_rd_i != 5'd0);
      rf_waddr_o = xif_rd_i;
      rf_wdata_o = xif_data_i;
      rf_xif_o   = 1'b1;
      rf_id_o    = xif_id_i;
    end
  end

  // Queue pointers, occupancy and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (pop || empty)
        starve_cnt <= '0;
      else if (wb_win && (starve_cnt != ST_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + ST_W'(1);
    end
  end

  // Queue storage; contents are only meaningful inside the occupied window
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= xif_rd_i;
      q_data[wr_ptr] <= xif_data_i;
      q_id[wr_ptr]   <= xif_id_i;
    end
  end

  // Detects a WB write to a non-zero rd that still has a queued XIF write
  always_comb begin
    rd_hazard = 1'b0;
    slot_off  = '0;
    for (int unsigned i = 0; i < XIF_FIFO_DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr;
      if (({1'b0, slot_off} < count) && (q_rd[i] == pipe_waddr_i) && (pipe_waddr_i != 5'd0))
        rd_hazard = 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_no_waw: assert property (@(posedge clk) disable iff (!rst_n) !(pipe_we_i && rd_hazard))
    else $error("WB write targets rd with a queued XIF write");
`endif

endmodule

// File: tb/tb_cv32e40x_rf_wport_arbiter.sv
// Directed bench for cv32e40x_rf_wport_arbiter (default parameters).
module tb_cv32e40x_rf_wport_arbiter;

  localparam int unsigned XW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pipe_we = 1'b0;
  logic [4:0]    pipe_waddr = '0;
  logic [31:0]   pipe_wdata = '0;
  logic          pipe_ready;
  logic          xif_valid = 1'b0;
  logic          xif_ready;
  logic          xif_we = 1'b0;
  logic [4:0]    xif_rd = '0;
  logic [31:0]   xif_data = '0;
  logic [XW-1:0] xif_id = '0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          rf_xif;
  logic [XW-1:0] rf_id;
  logic          fifo_empty;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  cv32e40x_rf_wport_arbiter #(
    .XIF_FIFO_DEPTH(4),
    .STARVE_LIMIT  (8),
    .X_ID_WIDTH    (XW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_we_i   (pipe_we),
    .pipe_waddr_i(pipe_waddr),
    .pipe_wdata_i(pipe_wdata),
    .pipe_ready_o(pipe_ready),
    .xif_valid_i (xif_valid),
    .xif_ready_o (xif_ready),
    .xif_we_i    (xif_we),
    .xif_rd_i    (xif_rd),
    .xif_data_i  (xif_data),
    .xif_id_i    (xif_id),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .rf_xif_o    (rf_xif),
    .rf_id_o     (rf_id),
    .fifo_empty_o(fifo_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_we = we; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic drive_xif(input logic v, input logic we, input logic [4:0] rd,
                           input logic [31:0] d, input logic [XW-1:0] id);
    xif_valid = v; xif_we = we; xif_rd = rd; xif_data = d; xif_id = id;
  endtask

  // Cycles (relative to start of the starvation sequence) where a forced drain is expected
  int force_cyc [5] = '{9, 18, 27, 36, 45};

  initial begin
    int fidx;
    // Reset state
    #2;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_xif", 32'(rf_xif), 32'd0);
    check("rst_pipe_ready", 32'(pipe_ready), 32'd1);
    check("rst_xif_ready", 32'(xif_ready), 32'd1);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: plain WB write
    @(negedge clk);
    drive_wb(1'b1, 5'd5, 32'hA5A5_0001);
    #2;
    check("t1_rf_we", 32'(rf_we), 32'd1);
    check("t1_waddr", 32'(rf_waddr), 32'd5);
    check("t1_wdata", rf_wdata, 32'hA5A5_0001);
    check("t1_pipe_ready", 32'(pipe_ready), 32'd1);
    check("t1_rf_xif", 32'(rf_xif), 32'd0);

    // 2: single XIF result with WB idle
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_xif(1'b1, 1'b1, 5'd7, 32'h1234, 4'd3);
    #2;
    check("t2_xif_ready", 32'(xif_ready), 32'd1);
`ifdef CV32E40X_RF_ARB_BYPASS_EN
    check("t2_byp_rf_we", 32'(rf_we), 32'd1);
    check("t2_byp_waddr", 32'(rf_waddr), 32'd7);
    check("t2_byp_rf_xif", 32'(rf_xif), 32'd1);
`else
    check("t2_no_write_yet", 32'(rf_we), 32'd0);
`endif
    @(negedge clk);
    drive_xif(1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
    #2;
`ifndef CV32E40X_RF_ARB_BYPASS_EN
    check("t2_rf_we", 32'(rf_we), 32'd1);
    check("t2_waddr", 32'(rf_waddr), 32'd7);
    check("t2_wdata", rf_wdata, 32'h1234);
    check("t2_rf_xif", 32'(rf_xif), 32'd1);
    check("t2_rf_id", 32'(rf_id), 32'd3);
    check("t2_fifo_nonempty", 32'(fifo_empty), 32'd0);
    @(negedge clk);
    #2;
`endif
    check("t2_fifo_empty", 32'(fifo_empty), 32'd1);
    check("t2_idle_rf_we", 32'(rf_we), 32'd0);

    // 3+4: fill under continuous WB, full backpressure, forced drains every 9th cycle
    fidx = 0;
    for (int c = 0; c < 47; c++) begin
      @(negedge clk);
      drive_wb(1'b1, 5'd20, 32'hBEEF_0000 + 32'(c));
      if (c < 4)
        drive_xif(1'b1, 1'b1, 5'(c + 1), 32'h100 + 32'(c + 1), XW'(c + 1));
      else if (c <= 10)
        drive_xif(1'b1, 1'b1, 5'd5, 32'h105, 4'd5);
      else
        drive_xif(1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
      #2;
      if (fidx < 5 && c == force_cyc[fidx]) begin
        check("t4_force_stall", 32'(pipe_ready), 32'd0);
        check("t4_force_waddr", 32'(rf_waddr), 32'(fidx + 1));
        check("t4_force_wdata", rf_wdata, 32'h100 + 32'(fidx + 1));
        check("t4_force_id", 32'(rf_id), 32'(fidx + 1));
        check("t4_force_xif", 32'(rf_xif), 32'd1);
        fidx++;
      end else begin
        check("t4_wb_ready", 32'(pipe_ready), 32'd1);
        check("t4_wb_waddr", 32'(rf_waddr), 32'd20);
        check("t4_wb_wdata", rf_wdata, 32'hBEEF_0000 + 32'(c));
      end
      if (c == 3)  check("t3_ready_cnt3", 32'(xif_ready), 32'd1);
      if (c == 4)  check("t3_full", 32'(xif_ready), 32'd0);
      if (c == 9)  check("t3_full_at_pop", 32'(xif_ready), 32'd0);
      if (c == 10) check("t3_ready_after_pop", 32'(xif_ready), 32'd1);
      if (c == 44) check("t4_not_drained", 32'(fifo_empty), 32'd0);
      if (c == 46) check("t4_drained", 32'(fifo_empty), 32'd1);
    end

    // 5: rd = x0 result is popped without writing; xif_we = 0 result is dropped
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_xif(1'b1, 1'b1, 5'd0, 32'hFF, 4'd6);
    #2;
    check("t5_x0_accept", 32'(xif_ready), 32'd1);
    check("t5_x0_no_we_c0", 32'(rf_we), 32'd0);
    @(negedge clk);
    drive_xif(1'b1, 1'b0, 5'd9, 32'h99, 4'd7);
    #2;
    check("t5_x0_no_we", 32'(rf_we), 32'd0);
`ifdef CV32E40X_RF_ARB_BYPASS_EN
    check("t5_x0_empty", 32'(fifo_empty), 32'd1);
`else
    check("t5_x0_popping", 32'(fifo_empty), 32'd0);
`endif
    check("t5_nowe_accept", 32'(xif_ready), 32'd1);
    @(negedge clk);
    drive_xif(1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
    #2;
    check("t5_nowe_dropped", 32'(fifo_empty), 32'd1);
    check("t5_nowe_no_write", 32'(rf_we), 32'd0);

    // 6: asynchronous reset with three queued results
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_wb(1'b1, 5'd20, 32'h600 + 32'(c));
      drive_xif(1'b1, 1'b1, 5'(c + 11), 32'h700 + 32'(c), XW'(c));
    end
    @(negedge clk);
    drive_xif(1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
    #2;
    check("t6_queued", 32'(fifo_empty), 32'd0);
    check("t6_wb_still_wins", 32'(rf_waddr), 32'd20);
    #1;
    drive_wb(1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_empty", 32'(fifo_empty), 32'd1);
    check("t6_rst_rf_we", 32'(rf_we), 32'd0);
    check("t6_rst_xif_ready", 32'(xif_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("t6_no_stale_we", 32'(rf_we), 32'd0);
    check("t6_no_stale_empty", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    #2;
    check("t6_still_idle", 32'(rf_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
